// File: rtl/tinyqv_mem_responder_if.sv
// ============================================================================
// Module   : tinyqv_mem_responder_if
// Brief    : Load/store request and nibble-data bus between tinyqv core and responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tinyqv_mem_responder_if;
   logic [27:0] addr_in;
   logic        addr_valid;
   logic        is_store;
   logic [1:0]  size;
   logic [3:0]  st_nibble;
   logic        st_valid;
   logic [3:0]  ld_nibble;
   logic        load_data_ready;
   logic        store_done;
   logic        busy;
   logic        err;

   modport master (
      output addr_in, addr_valid, is_store, size, st_nibble, st_valid,
      input  ld_nibble, load_data_ready, store_done, busy, err
   );

   modport slave (
      input  addr_in, addr_valid, is_store, size, st_nibble, st_valid,
      output ld_nibble, load_data_ready, store_done, busy, err
   );
endinterface

`default_nettype wire

// File: rtl/tinyqv_mem_responder.sv
// ============================================================================
// Module   : tinyqv_mem_responder
// Brief    : Nibble-serial byte RAM responder for the tinyqv load/store bus.
//            Optional: TINYQV_RESP_MISALIGN_EN allows misaligned half/word access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tinyqv_mem_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int READ_LATENCY = 2
) (
   input  wire logic               clk,
   input  wire logic               rst,
   tinyqv_mem_responder_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LD_WAIT    = 3'd1,
      S_LD_STREAM  = 3'd2,
      S_ST_COLLECT = 3'd3,
      S_ST_WRITE   = 3'd4
   } state_t;

   localparam int        C_DEPTH    = 1 << ADDR_BITS;
   localparam logic [3:0] C_LAT_INIT = 4'(READ_LATENCY - 1);

   state_t               r_state, w_next;
   logic [7:0]           r_mem [C_DEPTH];
   logic [ADDR_BITS-1:0] r_addr;
   logic [2:0]           r_nbytes;
   logic                 r_bad;
   logic [3:0]           r_lat;
   logic [2:0]           r_nib;
   logic [31:0]          r_ld_word;
   logic [31:0]          r_st_word;
   logic                 r_err;

   logic                 w_accept;
   logic                 w_out_of_range;
   logic                 w_misaligned;
   logic [2:0]           w_req_nbytes;
   logic [ADDR_BITS-1:0] w_src_addr;
   logic [2:0]           w_src_nbytes;
   logic                 w_src_bad;
   logic [31:0]          w_rd_word;

   function automatic logic [ADDR_BITS-1:0] byte_addr(input logic [ADDR_BITS-1:0] base,
                                                      input int i);
`ifdef TINYQV_RESP_MISALIGN_EN
      return base + ADDR_BITS'(i);
`else
      return base | ADDR_BITS'(i);
`endif
   endfunction

   assign w_accept       = (r_state == S_IDLE) && bus.addr_valid;
   assign w_out_of_range = |bus.addr_in[27:ADDR_BITS];
`ifdef TINYQV_RESP_MISALIGN_EN
   assign w_misaligned   = 1'b0;
`else
   assign w_misaligned   = ((bus.size == 2'd1) && bus.addr_in[0]) ||
                           (bus.size[1] && (bus.addr_in[1:0] != 2'd0));
`endif
   assign w_req_nbytes   = (bus.size == 2'd0) ? 3'd1 : (bus.size == 2'd1) ? 3'd2 : 3'd4;

   // With READ_LATENCY == 1 the stream starts straight from IDLE, before r_addr is latched.
   assign w_src_addr   = (r_state == S_IDLE) ? bus.addr_in[ADDR_BITS-1:0] : r_addr;
   assign w_src_nbytes = (r_state == S_IDLE) ? w_req_nbytes : r_nbytes;
   assign w_src_bad    = (r_state == S_IDLE) ? (w_out_of_range || w_misaligned) : r_bad;

   always_comb begin
      w_rd_word = 32'd0;
      for (int i = 0; i < 4; i++) begin
         if (!w_src_bad && (3'(i) < w_src_nbytes))
            w_rd_word[8*i +: 8] = r_mem[byte_addr(w_src_addr, i)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.addr_valid) begin
               if (bus.is_store)            w_next = S_ST_COLLECT;
               else if (READ_LATENCY == 1)  w_next = S_LD_STREAM;
               else                         w_next = S_LD_WAIT;
            end
         end
         S_LD_WAIT:    if (r_lat == 4'd1)                     w_next = S_LD_STREAM;
         S_LD_STREAM:  if (r_nib == 3'd7)                     w_next = S_IDLE;
         S_ST_COLLECT: if (bus.st_valid && (r_nib == 3'd7))   w_next = S_ST_WRITE;
         S_ST_WRITE:                                          w_next = S_IDLE;
         default:                                             w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= '0;
         r_nbytes  <= 3'd0;
         r_bad     <= 1'b0;
         r_lat     <= 4'd0;
         r_nib     <= 3'd0;
         r_ld_word <= 32'd0;
         r_st_word <= 32'd0;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_accept && (w_out_of_range || w_misaligned);
         if (w_accept) begin
            r_addr    <= bus.addr_in[ADDR_BITS-1:0];
            r_nbytes  <= w_req_nbytes;
            r_bad     <= w_out_of_range || w_misaligned;
            r_lat     <= C_LAT_INIT;
            r_nib     <= 3'd0;
            r_st_word <= 32'd0;
         end
         if (r_state == S_LD_WAIT)
            r_lat <= r_lat - 4'd1;
         if ((w_next == S_LD_STREAM) && (r_state != S_LD_STREAM)) begin
            r_ld_word <= w_rd_word;
         end else if (r_state == S_LD_STREAM) begin
            r_ld_word <= {4'd0, r_ld_word[31:4]};
            r_nib     <= r_nib + 3'd1;
         end
         if ((r_state == S_ST_COLLECT) && bus.st_valid) begin
            r_st_word[{r_nib, 2'b00} +: 4] <= bus.st_nibble;
            r_nib                          <= r_nib + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && (r_state == S_ST_WRITE) && !r_bad) begin
         for (int i = 0; i < 4; i++) begin
            if (3'(i) < r_nbytes)
               r_mem[byte_addr(r_addr, i)] <= r_st_word[8*i +: 8];
         end
      end
   end

   assign bus.load_data_ready = (r_state == S_LD_STREAM);
   assign bus.ld_nibble       = (r_state == S_LD_STREAM) ? r_ld_word[3:0] : 4'd0;
   assign bus.store_done      = (r_state == S_ST_WRITE);
   assign bus.busy            = (r_state != S_IDLE);
   assign bus.err             = r_err;

endmodule

`default_nettype wire
